// File: rtl/uart_word_rx.sv
// uart_word_rx -- UART receive front end that assembles 16-bit words.
//
// Receives 8N1 frames (LSB first) on an asynchronous serial line, checks the
// start and stop bits, and packs two consecutive bytes (high byte first) into
// one word for the FPU operand/opcode registers.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   rx         serial line, idle high, asynchronous to clk
//   data       last assembled word {first byte, second byte}; held until the
//              next word arrives
//   valid      one-cycle pulse: data holds a new word
//   frame_err  one-cycle pulse: bad stop bit or inter-byte timeout
//   busy       high while a frame is in progress (START..STOP)
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit time (must be >= 2)
//   TIMEOUT_BITS  idle bit-times allowed between the high and low byte
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] data,
  output logic        valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_W     = $clog2(TO_LIMIT);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic             rx_meta;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_byte;
  logic [7:0]       high_byte;
  logic             byte_sel;
  logic [TO_W-1:0]  to_cnt;

  // Two-flop synchroniser. 
  // NOTE: the flops preset to 1 (the idle line level), not 0, so that
  // releasing reset is never mistaken for a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments give the two-stage delay; blocking
      // ones would collapse the chain into a single flop.
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // busy is a pure decode of the state, so a continuous assign cannot
  // create a latch.
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_byte <= '0;
      high_byte  <= '0;
      byte_sel   <= 1'b0;
      to_cnt     <= '0;
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
          // Inter-byte timeout: only runs while a high byte is held and the
          // line is idle; entering a frame freezes it.
          if (byte_sel) begin
            if (to_cnt == TO_LAST) begin
              byte_sel  <= 1'b0;
              frame_err <= 1'b1;
              to_cnt    <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= IDLE;  // line came back high: a glitch, not a frame
            end else begin
              state   <= DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt                 <= '0;
            shift_byte[bit_idx] <= rx_s;
            bit_idx             <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          // Leave at the middle of the stop bit so a back-to-back start
          // edge is never missed.
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              byte_sel  <= 1'b0;
            end else if (!byte_sel) begin
              high_byte <= shift_byte;
              byte_sel  <= 1'b1;
              to_cnt    <= '0;
            end else begin
              data     <= {high_byte, shift_byte};
              valid    <= 1'b1;
              byte_sel <= 1'b0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_word_rx.md
Name: uart_word_rx

Overview:
- UART receive front end of the FPU: turns the serial `rx` line into 16-bit words for the operand (A, B) and opcode registers.
- Synchronises `rx` and samples each bit at its midpoint, 8N1, LSB first.
- Checks start and stop bits, packs two bytes (high byte first) into one word, and emits a one-cycle `valid` strobe.
- Sits directly upstream of the FPU control FSM, replacing the shift-register/counter receive path with one self-contained block.

Parameters:
- CLKS_PER_BIT, 434: system clocks per bit (50 MHz / 115200).
- TIMEOUT_BITS, 32: idle bit-times allowed between the high and low byte before the half-word is discarded.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data  output  16  last assembled word: {first byte, second byte}.
- valid  output  1  one-cycle pulse; `data` holds a new word.
- frame_err  output  1  one-cycle pulse on a bad stop bit or an inter-byte timeout.
- busy  output  1  high while a frame is in progress (START..STOP).

Behaviour:
- Reset (rst=0, async): state IDLE; data=16'h0000; valid=0; frame_err=0; busy=0; byte_sel=0. Synchroniser flops preset to 1, so no false start on release. Reset mid-frame abandons the frame and any held high byte.
- Input path: `rx` passes through 2 flops (rx_s). All decisions use rx_s, so there is a 2-cycle latency from pin to logic.
- Bit counter: cycle counter 0..CLKS_PER_BIT-1. Bit index 0..7.
- IDLE:
  - rx_s == 0 -> go to START, clear the cycle counter, busy=1.
- START:
  - At count CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
  - Sample 1 -> glitch: go to IDLE, busy=0, no error.
  - Sample 0 -> go to DATA, clear counter and bit index.
- DATA:
  - At each count CLKS_PER_BIT-1, shift rx_s into bit[index], LSB first.
  - After index 7 is sampled -> go to STOP.
- STOP:
  - At count CLKS_PER_BIT-1, sample rx_s and go to IDLE the next cycle. Returning mid-stop-bit allows back-to-back frames.
  - Sample 0 -> frame_err=1 for 1 cycle, byte discarded, byte_sel=0 (any held high byte is dropped).
  - Sample 1, byte_sel=0 -> store byte as high byte, byte_sel=1, start the timeout counter.
  - Sample 1, byte_sel=1 -> the cycle after the stop sample, data={high,byte} and valid=1 for exactly 1 cycle; byte_sel=0.
- Timeout:
  - While byte_sel=1 and state=IDLE, count clocks.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT -> byte_sel=0, frame_err=1 for 1 cycle.
  - Leaving IDLE stops the count. Each new high byte resets the count.
- `data` holds its value until the next valid word; it is never cleared except by reset.
- `valid` and `frame_err` are never high in the same cycle.
- `busy` is 0 in IDLE and 1 in START, DATA and STOP.
- rx_s held low (break) -> STOP sample 0 -> frame_err. The block then re-enters START while the line is still low; each further frame also fails, until the line returns high.
- Counter widths come from $clog2 of the maximum counts; no overflow at the default parameters.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=4):
- Reset then idle-high line -> valid, frame_err and busy stay 0; data=16'h0000.
- Send 8N1 bytes 8'h3C then 8'hA5 back-to-back -> exactly one valid pulse, 1 cycle wide, data=16'h3CA5; busy=0 between the stop sample and the next start edge.
- Low glitch of 4 clocks on rx -> START aborts, no valid, no frame_err; a following byte pair 8'h12 8'h34 -> data=16'h1234.
- Byte 8'hFF with stop bit=0 -> one frame_err pulse, no valid; then 8'h01 8'h02 -> data=16'h0102 (the earlier byte was not kept).
- Byte 8'h11, then idle for 80 clocks -> one frame_err pulse at 64 idle clocks; then 8'h22 8'h33 -> data=16'h2233.
- Assert rst during DATA of the second byte -> all outputs 0 immediately; after release, 8'hAB 8'hCD -> data=16'hABCD.
